// File: rtl/nonce_search_if.sv
// Request/result bundle between a search requester and the nonce search controller.
// SEARCH_ABORT_EN adds the abort request line.
interface nonce_search_if;
  logic         start;
  logic [95:0]  entry_12;
  logic [7:0]   target;
  logic         hash_done;
  logic [23:0]  H_out;
`ifdef SEARCH_ABORT_EN
  logic         abort;
`endif
  logic         hash_reset;
  logic [127:0] block_out;
  logic [31:0]  nonce;
  logic         busy;
  logic         found;
  logic         exhausted;
  logic         error;
  logic [31:0]  golden_nonce;
  logic [23:0]  golden_hash;

  modport slave (
`ifdef SEARCH_ABORT_EN
    input  abort,
`endif
    input  start, entry_12, target,
    input  hash_done, H_out,
    output hash_reset, block_out, nonce,
    output busy, found, exhausted, error,
    output golden_nonce, golden_hash
  );

  modport master (
`ifdef SEARCH_ABORT_EN
    output abort,
`endif
    output start, entry_12, target,
    output hash_done, H_out,
    input  hash_reset, block_out, nonce,
    input  busy, found, exhausted, error,
    input  golden_nonce, golden_hash
  );
endinterface

// File: rtl/nonce_search_ctrl.sv
// Nonce sweep sequencer around the micro_hash core; all outputs registered.
// Optional SEARCH_ABORT_EN adds an abort input that returns a busy search to IDLE.
module nonce_search_ctrl #(
  parameter logic [31:0] NONCE_START = 32'h0000_0000,
  parameter logic [31:0] NONCE_LAST  = 32'hFFFF_FFFF,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic           clk,
  input  logic           reset,
  nonce_search_if.slave  bus
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_HASH  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [95:0]   hdr_q, hdr_d;
  logic [7:0]    tgt_q, tgt_d;
  logic [31:0]   nonce_q, nonce_d;
  logic [127:0]  blk_q, blk_d;
  logic [23:0]   hash_q, hash_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          hrst_q, hrst_d;
  logic          found_q, found_d;
  logic          exh_q, exh_d;
  logic          err_q, err_d;
  logic [31:0]   gnon_q, gnon_d;
  logic [23:0]   ghash_q, ghash_d;
  logic          valid;
  logic          active;

  assign valid  = (hash_q[23:16] < tgt_q) &&
                  (hash_q[15:8]  < tgt_q);
  assign active = (state_q == S_LOAD) ||
                  (state_q == S_HASH) ||
                  (state_q == S_CHECK);

  // Next-state and datapath update for the search FSM
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    tgt_d   = tgt_q;
    nonce_d = nonce_q;
    blk_d   = blk_q;
    hash_d  = hash_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    exh_d   = exh_q;
    err_d   = err_q;
    gnon_d  = gnon_q;
    ghash_d = ghash_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          hdr_d   = bus.entry_12;
          tgt_d   = bus.target;
          nonce_d = NONCE_START;
          blk_d   = {bus.entry_12, NONCE_START};
          found_d = 1'b0;
          exh_d   = 1'b0;
          err_d   = 1'b0;
          gnon_d  = '0;
          ghash_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_HASH;
      end
      S_HASH: begin
        if (bus.hash_done) begin
          hash_d  = bus.H_out;
          state_d = S_CHECK;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CHECK: begin
        if (valid) begin
          found_d = 1'b1;
          gnon_d  = nonce_q;
          ghash_d = hash_q;
          state_d = S_DONE;
        end else if (nonce_q == NONCE_LAST) begin
          exh_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          nonce_d = nonce_q + 32'd1;
          blk_d   = {hdr_q, nonce_q + 32'd1};
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SEARCH_ABORT_EN
    // Abort overrides whatever the busy state decided this cycle
    if (bus.abort && active) begin
      state_d = S_IDLE;
      nonce_d = nonce_q;
      blk_d   = blk_q;
      hash_d  = hash_q;
      found_d = 1'b0;
      exh_d   = 1'b0;
      err_d   = 1'b0;
    end
`endif
    busy_d = (state_d == S_LOAD) ||
             (state_d == S_HASH) ||
             (state_d == S_CHECK);
    hrst_d = (state_d != S_HASH);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      tgt_q   <= '0;
      nonce_q <= '0;
      blk_q   <= '0;
      hash_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hrst_q  <= 1'b1;
      found_q <= 1'b0;
      exh_q   <= 1'b0;
      err_q   <= 1'b0;
      gnon_q  <= '0;
      ghash_q <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      tgt_q   <= tgt_d;
      nonce_q <= nonce_d;
      blk_q   <= blk_d;
      hash_q  <= hash_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hrst_q  <= hrst_d;
      found_q <= found_d;
      exh_q   <= exh_d;
      err_q   <= err_d;
      gnon_q  <= gnon_d;
      ghash_q <= ghash_d;
    end
  end

  assign bus.hash_reset   = hrst_q;
  assign bus.block_out    = blk_q;
  assign bus.nonce        = nonce_q;
  assign bus.busy         = busy_q;
  assign bus.found        = found_q;
  assign bus.exhausted    = exh_q;
  assign bus.error        = err_q;
  assign bus.golden_nonce = gnon_q;
  assign bus.golden_hash  = ghash_q;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Directed bench for nonce_search_ctrl with a micro_hash stub.
// Define SEARCH_ABORT_EN to also exercise abort.
module tb_nonce_search_ctrl;

  localparam logic [95:0] HDR  = 96'h0102030405060708090A0B0C;
  localparam logic [95:0] HDR2 = 96'hA1A2A3A4A5A6A7A8A9AAABAC;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   pulses = 0;
  logic prev_hr = 1'b1;
  int   scnt = 0;
  int   mode = 1;
  int   p0, t0, t1;
  bit   ok;

  nonce_search_if bus();

  nonce_search_ctrl #(
    .NONCE_START (32'd0),
    .NONCE_LAST  (32'd7),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_hr <= bus.hash_reset;
    if (prev_hr === 1'b1 && bus.hash_reset === 1'b0)
      pulses <= pulses + 1;
  end

  // Stub: mode 0 never done, 1 valid at nonce 3, 2 never valid
  always @(posedge clk) begin
    if (reset || bus.hash_reset !== 1'b0) begin
      scnt          <= 0;
      bus.hash_done <= 1'b0;
      bus.H_out     <= 24'h0;
    end else begin
      scnt <= scnt + 1;
      if (scnt == 4 && mode != 0) begin
        bus.hash_done <= 1'b1;
        bus.H_out     <= (mode == 1 && bus.nonce == 32'd3) ?
                         24'h0F0E55 : 24'hFFFFFF;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_search(input logic [95:0] h,
                              input logic [7:0] t);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.entry_12 = h;
    bus.target   = t;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit done = 0;
    for (int i = 0; i < 400; i++) begin
      if (!done) begin
        @(negedge clk);
        if (bus.busy === 1'b0) done = 1;
      end
    end
    chk(tag, 128'(done), 128'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hr"},   128'(bus.hash_reset), 128'd1);
    chk({tag, "_busy"}, 128'(bus.busy), 128'd0);
    chk({tag, "_flg"},
        128'({bus.found, bus.exhausted, bus.error}), 128'd0);
    chk({tag, "_non"},  128'(bus.nonce), 128'd0);
    chk({tag, "_blk"},  bus.block_out, 128'd0);
    chk({tag, "_gold"},
        128'({bus.golden_nonce, bus.golden_hash}), 128'd0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.entry_12 = '0;
    bus.target   = '0;
`ifdef SEARCH_ABORT_EN
    bus.abort    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;

    // T1 found at nonce 3
    mode = 1;
    p0 = pulses;
    start_search(HDR, 8'h10);
    chk("t1_busy", 128'(bus.busy), 128'd1);
    wait_done("t1_wait");
    chk("t1_found", 128'(bus.found), 128'd1);
    chk("t1_other", 128'({bus.exhausted, bus.error}), 128'd0);
    chk("t1_gnon", 128'(bus.golden_nonce), 128'd3);
    chk("t1_ghash", 128'(bus.golden_hash), 128'h0F0E55);
    chk("t1_pulses", 128'(pulses - p0), 128'd4);
    chk("t1_blk", bus.block_out, {HDR, 32'd3});
    chk("t1_hr", 128'(bus.hash_reset), 128'd1);

    // T2 exhausted at NONCE_LAST
    mode = 2;
    p0 = pulses;
    start_search(HDR, 8'h10);
    wait_done("t2_wait");
    chk("t2_exh", 128'(bus.exhausted), 128'd1);
    chk("t2_found", 128'(bus.found), 128'd0);
    chk("t2_err", 128'(bus.error), 128'd0);
    chk("t2_nonce", 128'(bus.nonce), 128'd7);
    chk("t2_pulses", 128'(pulses - p0), 128'd8);
    chk("t2_blk", 128'(bus.block_out[31:0]), 128'd7);

    // T3 hash-core timeout
    mode = 0;
    start_search(HDR, 8'h10);
    ok = 0;
    for (int i = 0; i < 20; i++)
      if (!ok) begin
        if (bus.hash_reset === 1'b0) ok = 1;
        else @(negedge clk);
      end
    chk("t3_hash", 128'(ok), 128'd1);
    t0 = cyc;
    ok = 0;
    for (int i = 0; i < 60; i++)
      if (!ok) begin
        @(negedge clk);
        if (bus.error === 1'b1) ok = 1;
      end
    t1 = cyc;
    chk("t3_err", 128'(ok), 128'd1);
    chk("t3_cycles", 128'(t1 - t0), 128'd16);
    chk("t3_hr", 128'(bus.hash_reset), 128'd1);
    chk("t3_busy", 128'(bus.busy), 128'd0);
    chk("t3_other", 128'({bus.found, bus.exhausted}), 128'd0);
    repeat (2) @(negedge clk);
    chk("t3_hr_hold", 128'(bus.hash_reset), 128'd1);

    // T4 start while busy is ignored, start in DONE restarts
    mode = 1;
    start_search(HDR, 8'h10);
    repeat (3) @(negedge clk);
    bus.start    = 1'b1;
    bus.entry_12 = HDR2;
    bus.target   = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("t4_wait");
    chk("t4_found", 128'(bus.found), 128'd1);
    chk("t4_gnon", 128'(bus.golden_nonce), 128'd3);
    chk("t4_hdr", 128'(bus.block_out[127:32]), 128'(HDR));
    start_search(HDR2, 8'h10);
    chk("t4_clr", 128'({bus.found, bus.exhausted, bus.error}),
        128'd0);
    chk("t4_gclr",
        128'({bus.golden_nonce, bus.golden_hash}), 128'd0);
    chk("t4_nonce", 128'(bus.nonce), 128'd0);
    chk("t4_hdr2", 128'(bus.block_out[127:32]), 128'(HDR2));
    chk("t4_busy", 128'(bus.busy), 128'd1);
    wait_done("t4_wait2");
    chk("t4_found2", 128'(bus.found), 128'd1);

    // T5 reset during HASH
    mode = 1;
    start_search(HDR, 8'h10);
    ok = 0;
    for (int i = 0; i < 40; i++)
      if (!ok) begin
        @(negedge clk);
        if (bus.hash_reset === 1'b0 && bus.nonce == 32'd1) ok = 1;
      end
    chk("t5_hash", 128'(ok), 128'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("t5");
    start_search(HDR2, 8'h10);
    wait_done("t5_wait");
    chk("t5_found", 128'(bus.found), 128'd1);
    chk("t5_gnon", 128'(bus.golden_nonce), 128'd3);
    chk("t5_blk", bus.block_out, {HDR2, 32'd3});

`ifdef SEARCH_ABORT_EN
    // T6 abort during HASH at nonce 2, then abort+start in DONE
    mode = 2;
    start_search(HDR, 8'h10);
    ok = 0;
    for (int i = 0; i < 60; i++)
      if (!ok) begin
        @(negedge clk);
        if (bus.hash_reset === 1'b0 && bus.nonce == 32'd2) ok = 1;
      end
    chk("t6_hash", 128'(ok), 128'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("t6_busy", 128'(bus.busy), 128'd0);
    chk("t6_hr", 128'(bus.hash_reset), 128'd1);
    chk("t6_nonce", 128'(bus.nonce), 128'd2);
    chk("t6_flg", 128'({bus.found, bus.exhausted, bus.error}),
        128'd0);
    repeat (10) @(negedge clk);
    chk("t6_idle", 128'(bus.busy), 128'd0);
    mode = 1;
    start_search(HDR, 8'h10);
    wait_done("t6_wait");
    chk("t6_found", 128'(bus.found), 128'd1);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.abort    = 1'b1;
    bus.entry_12 = HDR2;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("t6_restart", 128'(bus.busy), 128'd1);
    chk("t6_rclr", 128'(bus.found), 128'd0);
    chk("t6_rhdr", 128'(bus.block_out[127:32]), 128'(HDR2));
    wait_done("t6_wait2");
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
